spi_flash_responder: RTL and testbench

//  Synthesizable SPI NOR-flash responder: the device end of the SoC flash SPI master (flash_spi_clk/mosi/cs/miso pads).

---
 rtl/spi_flash_pkg.sv | 29 ++
 rtl/spi_in_sync.sv | 51 +++++
 rtl/spi_flash_responder.sv | 216 +++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI NOR-flash responder: opcodes, FSM states and
// the JEDEC ID byte selector.
package spi_flash_pkg;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_RDID      = 8'h9F;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    ID,
    IGNORE
  } spi_resp_state_e;

  // ID bytes go out MSB first; anything past the third byte reads as zero.
  function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
    case (idx)
      2'd0:    id_byte = id[23:16];
      2'd1:    id_byte = id[15:8];
      2'd2:    id_byte = id[7:0];
      default: id_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Synchronizer for the asynchronous SPI pads (SCK, CS#, MOSI) plus SCK edge
// pulses derived from the synchronized clock.
module spi_in_sync #(
  parameter int SYNC_FF = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic sck_i,
  input  logic cs_n_i,
  input  logic mosi_i,
  output logic cs_n_s,
  output logic mosi_s,
  output logic sck_rise,
  output logic sck_fall
);

  // Bit order per stage: {sck, cs_n, mosi}; CS# rests deasserted.
  localparam logic [2:0] RESET_VAL = 3'b010;

  logic [SYNC_FF-1:0][2:0] stage_reg;
  logic                    sck_s;
  logic                    sck_prev_reg;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_FF; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clock) begin
          if (reset) stage_reg[0] <= RESET_VAL;
          else       stage_reg[0] <= {sck_i, cs_n_i, mosi_i};
        end
      end else begin : g_next
        always_ff @(posedge clock) begin
          if (reset) stage_reg[gi] <= RESET_VAL;
          else       stage_reg[gi] <= stage_reg[gi-1];
        end
      end
    end
  endgenerate

  assign {sck_s, cs_n_s, mosi_s} = stage_reg[SYNC_FF-1];

  always_ff @(posedge clock) begin
    if (reset) sck_prev_reg <= 1'b0;
    else       sck_prev_reg <= sck_s;
  end

  assign sck_rise = sck_s & ~sck_prev_reg;
  assign sck_fall = ~sck_s & sck_prev_reg;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI NOR-flash responder (mode 0): READ / RDID decode, one-byte prefetch from a
// byte-wide memory port. Define SPI_RESP_FAST_READ_EN to accept FAST READ (0x0B).
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int          ADDR_W   = 24,
  parameter logic [23:0] JEDEC_ID = 24'hEF4016,
  parameter int          SYNC_FF  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              spi_clk_i,
  input  logic              spi_cs_n_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_oe_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [7:0]        mem_rdata_i,
  output logic              busy_o,
  output logic              cmd_err_o,
  output logic              underrun_o
);

  logic cs_n_s, mosi_s, sck_rise, sck_fall;

  spi_in_sync #(.SYNC_FF(SYNC_FF)) u_sync (
    .clock    (clock),
    .reset    (reset),
    .sck_i    (spi_clk_i),
    .cs_n_i   (spi_cs_n_i),
    .mosi_i   (spi_mosi_i),
    .cs_n_s   (cs_n_s),
    .mosi_s   (mosi_s),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall)
  );

  spi_resp_state_e   state_reg;
  logic [4:0]        bit_cnt_reg;
  logic [22:0]       shift_in_reg;
  logic              fast_reg;
  logic              load_pend_reg;
  logic              req_en_reg;
  logic [1:0]        id_idx_reg;
  logic [7:0]        tx_reg;
  logic [7:0]        buf_reg;
  logic              buf_valid_reg;
  logic              miso_reg;
  logic              oe_reg;
  logic              mem_req_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic              cmd_err_reg;
  logic              underrun_reg;

  logic [23:0] rx_word;
  logic [7:0]  rx_op;
  logic        ack_hit;
  logic [7:0]  load_byte;

  assign rx_word = {shift_in_reg, mosi_s};
  assign rx_op   = rx_word[7:0];
  assign ack_hit = mem_req_reg & mem_ack_i;

  // Byte presented to the shifter at a load: buffered data, else same-cycle ack
  // data, else the underrun filler.
  always_comb begin
    load_byte = 8'hFF;
    if (state_reg == ID)  load_byte = id_byte(JEDEC_ID, id_idx_reg);
    else if (buf_valid_reg) load_byte = buf_reg;
    else if (ack_hit)       load_byte = mem_rdata_i;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      shift_in_reg  <= '0;
      fast_reg      <= 1'b0;
      load_pend_reg <= 1'b0;
      req_en_reg    <= 1'b0;
      id_idx_reg    <= '0;
      tx_reg        <= 8'hFF;
      buf_reg       <= '0;
      buf_valid_reg <= 1'b0;
      miso_reg      <= 1'b1;
      oe_reg        <= 1'b0;
      mem_req_reg   <= 1'b0;
      mem_addr_reg  <= '0;
      cmd_err_reg   <= 1'b0;
      underrun_reg  <= 1'b0;
    end else begin
      cmd_err_reg  <= 1'b0;
      underrun_reg <= 1'b0;
      if (cs_n_s) begin
        state_reg     <= IDLE;
        bit_cnt_reg   <= '0;
        load_pend_reg <= 1'b0;
        req_en_reg    <= 1'b0;
        buf_valid_reg <= 1'b0;
        miso_reg      <= 1'b1;
        oe_reg        <= 1'b0;
        mem_req_reg   <= 1'b0;
      end else begin
        // Prefetch handshake; the next address is requested once the buffer is free.
        if (ack_hit) begin
          mem_req_reg   <= 1'b0;
          mem_addr_reg  <= mem_addr_reg + {{(ADDR_W-1){1'b0}}, 1'b1};
          buf_reg       <= mem_rdata_i;
          buf_valid_reg <= 1'b1;
        end else if (req_en_reg && !mem_req_reg && !buf_valid_reg) begin
          mem_req_reg <= 1'b1;
        end

        if (state_reg == IDLE) begin
          state_reg   <= CMD;
          bit_cnt_reg <= '0;
        end else if (sck_rise) begin
          case (state_reg)
            CMD: begin
              shift_in_reg <= rx_word[22:0];
              bit_cnt_reg  <= bit_cnt_reg + 5'd1;
              if (bit_cnt_reg == 5'd7) begin
                bit_cnt_reg <= '0;
                if (rx_op == OP_READ) begin
                  state_reg <= ADDR;
                  fast_reg  <= 1'b0;
                end
`ifdef SPI_RESP_FAST_READ_EN
                else if (rx_op == OP_FAST_READ) begin
                  state_reg <= ADDR;
                  fast_reg  <= 1'b1;
                end
`else
                else if (rx_op == OP_FAST_READ) begin
                  state_reg   <= IGNORE;
                  cmd_err_reg <= 1'b1;
                end
`endif
                else if (rx_op == OP_RDID) begin
                  state_reg     <= ID;
                  load_pend_reg <= 1'b1;
                  id_idx_reg    <= '0;
                end else begin
                  state_reg   <= IGNORE;
                  cmd_err_reg <= 1'b1;
                end
              end
            end
            ADDR: begin
              shift_in_reg <= rx_word[22:0];
              bit_cnt_reg  <= bit_cnt_reg + 5'd1;
              if (bit_cnt_reg == 5'd23) begin
                bit_cnt_reg  <= '0;
                mem_req_reg  <= 1'b1;
                req_en_reg   <= 1'b1;
                mem_addr_reg <= rx_word[ADDR_W-1:0];
                if (fast_reg) begin
                  state_reg <= DUMMY;
                end else begin
                  state_reg     <= DATA;
                  load_pend_reg <= 1'b1;
                end
              end
            end
            DUMMY: begin
              bit_cnt_reg <= bit_cnt_reg + 5'd1;
              if (bit_cnt_reg == 5'd7) begin
                bit_cnt_reg   <= '0;
                state_reg     <= DATA;
                load_pend_reg <= 1'b1;
              end
            end
            DATA, ID: begin
              bit_cnt_reg <= bit_cnt_reg + 5'd1;
              if (bit_cnt_reg[2:0] == 3'd7) begin
                bit_cnt_reg   <= '0;
                load_pend_reg <= 1'b1;
              end
            end
            default: ;
          endcase
        end else if (sck_fall && (state_reg == DATA || state_reg == ID)) begin
          if (load_pend_reg) begin
            load_pend_reg <= 1'b0;
            oe_reg        <= 1'b1;
            tx_reg        <= load_byte;
            miso_reg      <= load_byte[7];
            if (state_reg == ID) begin
              if (id_idx_reg != 2'd3) id_idx_reg <= id_idx_reg + 2'd1;
            end else if (buf_valid_reg) begin
              buf_valid_reg <= ack_hit;
            end else if (ack_hit) begin
              buf_valid_reg <= 1'b0;
            end else begin
              underrun_reg <= 1'b1;
            end
          end else begin
            tx_reg   <= {tx_reg[6:0], 1'b0};
            miso_reg <= tx_reg[6];
          end
        end
      end
    end
  end

  assign spi_miso_o    = miso_reg;
  assign spi_miso_oe_o = oe_reg;
  assign mem_req_o     = mem_req_reg;
  assign mem_addr_o    = mem_addr_reg;
  assign busy_o        = ~cs_n_s & (state_reg != IDLE);
  assign cmd_err_o     = cmd_err_reg;
  assign underrun_o    = underrun_reg;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench for spi_flash_responder: directed SPI transactions push
// expected MISO bytes and memory addresses; monitors pop and compare.
module tb_spi_flash_responder;

  localparam int HALF = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        spi_clk_i = 1'b0;
  logic        spi_cs_n_i = 1'b1;
  logic        spi_mosi_i = 1'b0;
  logic        mem_ack_i = 1'b0;
  logic [7:0]  mem_rdata_i = 8'h00;
  logic        spi_miso_o, spi_miso_oe_o, mem_req_o, busy_o, cmd_err_o, underrun_o;
  logic [23:0] mem_addr_o;

  spi_flash_responder dut (
    .clock         (clock),
    .reset         (reset),
    .spi_clk_i     (spi_clk_i),
    .spi_cs_n_i    (spi_cs_n_i),
    .spi_mosi_i    (spi_mosi_i),
    .spi_miso_o    (spi_miso_o),
    .spi_miso_oe_o (spi_miso_oe_o),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_ack_i     (mem_ack_i),
    .mem_rdata_i   (mem_rdata_i),
    .busy_o        (busy_o),
    .cmd_err_o     (cmd_err_o),
    .underrun_o    (underrun_o)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_miso_q[$];
  logic [23:0] exp_addr_q[$];
  logic [7:0]  mem [int];
  int          ack_delay = 2;

  int   req_total = 0, err_cycles = 0, urun_cycles = 0, oe_cycles = 0;
  logic req_prev = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  int   rx_bits = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  function automatic logic [7:0] mem_byte(input int a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  // Memory model: ack ack_delay cycles after a request, unless it is withdrawn.
  initial forever begin
    @(negedge clock);
    mem_ack_i = 1'b0;
    if (mem_req_o && !reset) begin
      for (int i = 0; i < ack_delay; i++) begin
        @(negedge clock);
        if (!mem_req_o) break;
      end
      if (mem_req_o) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = mem_byte(int'(mem_addr_o));
      end
    end
  end

  // Request / pulse monitor.
  initial forever begin
    @(negedge clock);
    if (mem_req_o && !req_prev) begin
      req_total++;
      if (exp_addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mem_addr: unexpected request to 0x%0h, none required", mem_addr_o);
      end else begin
        check("mem_addr", 32'(mem_addr_o), 32'(exp_addr_q.pop_front()));
      end
    end
    req_prev = mem_req_o;
    if (cmd_err_o)     err_cycles++;
    if (underrun_o)    urun_cycles++;
    if (spi_miso_oe_o) oe_cycles++;
  end

  // MISO monitor: master-side sampling on SCK rise while the pad is driven.
  initial forever begin
    @(posedge spi_clk_i or posedge spi_cs_n_i);
    if (spi_cs_n_i) begin
      rx_bits = 0;
    end else if (spi_miso_oe_o) begin
      rx_byte = {rx_byte[6:0], spi_miso_o};
      rx_bits++;
      if (rx_bits == 8) begin
        rx_bits = 0;
        if (exp_miso_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL miso_byte: unexpected byte 0x%0h, none required", rx_byte);
        end else begin
          check("miso_byte", 32'(rx_byte), 32'(exp_miso_q.pop_front()));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic spi_bits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      spi_mosi_i = val[i];
      tick(HALF);
      spi_clk_i = 1'b1;
      tick(HALF);
      spi_clk_i = 1'b0;
    end
  endtask

  task automatic cs_begin();
    tick(2);
    spi_cs_n_i = 1'b0;
    tick(4);
  endtask

  // CS# rises in the same step as the final SCK fall, so that fall loads nothing.
  task automatic cs_end();
    spi_cs_n_i = 1'b1;
    spi_mosi_i = 1'b0;
    tick(12);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"},     32'(spi_miso_o), 32'h1);
    check({tag, "_oe"},       32'(spi_miso_oe_o), 32'h0);
    check({tag, "_req"},      32'(mem_req_o), 32'h0);
    check({tag, "_addr"},     32'(mem_addr_o), 32'h0);
    check({tag, "_busy"},     32'(busy_o), 32'h0);
    check({tag, "_cmd_err"},  32'(cmd_err_o), 32'h0);
    check({tag, "_underrun"}, 32'(underrun_o), 32'h0);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_queues_empty"}, 32'(exp_miso_q.size() + exp_addr_q.size()), 32'h0);
    exp_miso_q.delete();
    exp_addr_q.delete();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int base_req, base_err, base_urun, base_oe;
    mem[32'h10] = 8'hA5;  mem[32'h11] = 8'h3C;
    mem[32'h0]  = 8'h81;  mem[32'hFFFFFF] = 8'h12;
    mem[32'h20] = 8'h5A;  mem[32'h30] = 8'h77;  mem[32'h31] = 8'h99;

    tick(3);
    check_reset_outputs("reset");
    reset = 1'b0;
    tick(4);

    // 1: READ 0x000010, two bytes
    base_req = req_total; base_urun = urun_cycles;
    exp_addr_q = '{24'h10, 24'h11, 24'h12};
    exp_miso_q = '{8'hA5, 8'h3C};
    cs_begin(); spi_bits(32'h03, 8); spi_bits(32'h10, 24); spi_bits(0, 16); cs_end();
    check("t1_req_count", 32'(req_total - base_req), 32'd3);
    check("t1_underrun", 32'(urun_cycles - base_urun), 32'd0);
    check("t1_busy_after", 32'(busy_o), 32'h0);
    check_drained("t1");

    // 2: RDID, four bytes
    base_req = req_total;
    exp_miso_q = '{8'hEF, 8'h40, 8'h16, 8'h00};
    cs_begin(); spi_bits(32'h9F, 8); spi_bits(0, 32); cs_end();
    check("t2_req_count", 32'(req_total - base_req), 32'd0);
    check_drained("t2");

    // 3: unsupported opcode
    base_req = req_total; base_err = err_cycles; base_oe = oe_cycles;
    cs_begin(); spi_bits(32'h55, 8); spi_bits(0, 16); cs_end();
    check("t3_cmd_err_cycles", 32'(err_cycles - base_err), 32'd1);
    check("t3_oe_cycles", 32'(oe_cycles - base_oe), 32'd0);
    check("t3_req_count", 32'(req_total - base_req), 32'd0);
    check_drained("t3");

    // 4: abort after 12 address bits, then a normal READ 0x000000
    base_req = req_total;
    cs_begin(); spi_bits(32'h03, 8); spi_bits(32'hABC, 12); cs_end();
    check("t4_busy_abort", 32'(busy_o), 32'h0);
    check("t4_oe_abort", 32'(spi_miso_oe_o), 32'h0);
    check("t4_req_abort", 32'(req_total - base_req), 32'd0);
    exp_addr_q = '{24'h0, 24'h1};
    exp_miso_q = '{8'h81};
    cs_begin(); spi_bits(32'h03, 8); spi_bits(32'h0, 24); spi_bits(0, 8); cs_end();
    check("t4_req_count", 32'(req_total - base_req), 32'd2);
    check_drained("t4");

    // 5: address wrap at the top of memory
    base_req = req_total;
    exp_addr_q = '{24'hFFFFFF, 24'h000000, 24'h000001};
    exp_miso_q = '{8'h12, 8'h81};
    cs_begin(); spi_bits(32'h03, 8); spi_bits(32'hFFFFFF, 24); spi_bits(0, 16); cs_end();
    check("t5_req_count", 32'(req_total - base_req), 32'd3);
    check_drained("t5");

    // 6: ack withheld past the first load -> 0xFF then the late byte
    base_req = req_total; base_urun = urun_cycles;
    ack_delay = 40;
    exp_addr_q = '{24'h20, 24'h21};
    exp_miso_q = '{8'hFF, 8'h5A};
    cs_begin(); spi_bits(32'h03, 8); spi_bits(32'h20, 24); spi_bits(0, 16); cs_end();
    ack_delay = 2;
    check("t6_underrun_cycles", 32'(urun_cycles - base_urun), 32'd1);
    check("t6_req_count", 32'(req_total - base_req), 32'd2);
    check_drained("t6");

    // 7: reset in the middle of the data phase
    base_req = req_total;
    exp_addr_q = '{24'h30, 24'h31, 24'h32};
    exp_miso_q = '{8'h77};
    cs_begin(); spi_bits(32'h03, 8); spi_bits(32'h30, 24); spi_bits(0, 12);
    check("t7_busy_before", 32'(busy_o), 32'h1);
    reset = 1'b1;
    tick(1);
    check_reset_outputs("t7");
    spi_cs_n_i = 1'b1;
    reset = 1'b0;
    tick(12);
    check("t7_req_count", 32'(req_total - base_req), 32'd3);
    check_drained("t7");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
